// File: rtl/psram_arbiter_if.sv
// Requester and memCtrl signal bundle for the PSRAM arbiter.
// The slave modport is the arbiter's view; master is the requesters and memCtrl side.
interface psram_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [23:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p0_bank;
  logic        p0_ack;
  logic [7:0]  p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [23:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic        p1_bank;
  logic        p1_ack;
  logic [7:0]  p1_rdata;

  logic        o_cs;
  logic        o_write;
  logic [23:0] o_address;
  logic        o_bank;
  logic [7:0]  o_dataToWrite;
  logic        i_busy;
  logic        i_dataReady;
  logic [7:0]  i_dataRead;
  logic [1:0]  o_grant;
  logic        o_timeout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_bank,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_bank,
    output p1_ack, p1_rdata,
    output o_cs, o_write, o_address, o_bank, o_dataToWrite,
    input  i_busy, i_dataReady, i_dataRead,
    output o_grant, o_timeout
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_bank,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_bank,
    input  p1_ack, p1_rdata,
    input  o_cs, o_write, o_address, o_bank, o_dataToWrite,
    output i_busy, i_dataReady, i_dataRead,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/psram_arbiter.sv
// Sequences memCtrl between the video port (0, priority) and CPU port (1, bounded-burst fairness).
// One access at a time; o_cs is a one-cycle low strobe; stalled accesses abort after TIMEOUT cycles.
module psram_arbiter #(
  parameter int MAX_P0_BURST = 4,
  parameter int TIMEOUT      = 1024,
  parameter int TO_W         = 11
) (
  input  logic            clkSys,
  input  logic            rst,
  psram_arbiter_if.slave  bus
);

  localparam int BC_W = $clog2(MAX_P0_BURST + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_P0_BURST);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    DONE
  } state_t;

  state_t          state;
  logic [BC_W-1:0] burst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            cur_port;

  logic any_req;
  logic pick_p1;
  logic fin_ok;
  logic fin_abort;

  assign any_req = bus.p0_req | bus.p1_req;
  // Port 1 wins alone, or when port 0 has used up its burst allowance.
  assign pick_p1 = bus.p1_req & (~bus.p0_req | (burst_cnt == BURST_MAX));

  assign fin_ok = (state == WAIT_DONE) & ~bus.i_busy & (bus.o_write | bus.i_dataReady);
  assign fin_abort = (to_cnt == TO_LAST) &
                     (((state == WAIT_START) & ~bus.i_busy) | ((state == WAIT_DONE) & ~fin_ok));

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      burst_cnt         <= '0;
      to_cnt            <= '0;
      cur_port          <= 1'b0;
      bus.o_cs          <= 1'b1;
      bus.o_write       <= 1'b0;
      bus.o_address     <= '0;
      bus.o_dataToWrite <= '0;
      bus.o_bank        <= 1'b1;
      bus.p0_ack        <= 1'b0;
      bus.p1_ack        <= 1'b0;
      bus.p0_rdata      <= '0;
      bus.p1_rdata      <= '0;
      bus.o_grant       <= 2'b00;
      bus.o_timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.i_busy && any_req) begin
            cur_port <= pick_p1;
            bus.o_cs <= 1'b0;
            state    <= ISSUE;
            if (pick_p1) begin
              bus.o_write       <= bus.p1_we;
              bus.o_address     <= bus.p1_addr;
              bus.o_dataToWrite <= bus.p1_wdata;
              bus.o_bank        <= bus.p1_bank;
              bus.o_grant       <= 2'b10;
              burst_cnt         <= '0;
            end else begin
              bus.o_write       <= bus.p0_we;
              bus.o_address     <= bus.p0_addr;
              bus.o_dataToWrite <= bus.p0_wdata;
              bus.o_bank        <= bus.p0_bank;
              bus.o_grant       <= 2'b01;
              if (!bus.p1_req)
                burst_cnt <= '0;
              else if (burst_cnt != BURST_MAX)
                burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end

        ISSUE: begin
          bus.o_cs <= 1'b1;
          to_cnt   <= '0;
          state    <= WAIT_START;
        end

        WAIT_START, WAIT_DONE: begin
          if (fin_ok || fin_abort) begin
            state <= DONE;
            if (cur_port) bus.p1_ack <= 1'b1;
            else          bus.p0_ack <= 1'b1;
            // Aborted reads return all-ones so the requester never sees stale data.
            if (!bus.o_write) begin
              if (cur_port) bus.p1_rdata <= fin_ok ? bus.i_dataRead : 8'hFF;
              else          bus.p0_rdata <= fin_ok ? bus.i_dataRead : 8'hFF;
            end
            if (fin_abort) bus.o_timeout <= 1'b1;
          end else if ((state == WAIT_START) && bus.i_busy) begin
            to_cnt <= '0;
            state  <= WAIT_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        DONE: begin
          bus.p0_ack  <= 1'b0;
          bus.p1_ack  <= 1'b0;
          bus.o_grant <= 2'b00;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-port arbiter sequencing the single PSRAM memory controller (memCtrl) between the VIC6569 video fetch port (port 0) and the 6502 CPU bus port (port 1).
- Sits between the requesters and memCtrl's i_cs/i_write/i_address/i_bank/i_dataToWrite and o_busy/o_dataReady/o_dataRead interface.
- Applies fixed priority to port 0 with a bounded-burst fairness rule for port 1.
- Drives memCtrl's chip-select strobe and completion handshake, and guards against a hung controller with a timeout.

Parameters:
- MAX_P0_BURST, 4: consecutive port-0 grants allowed while port 1 is pending before port 1 is forced.
- TIMEOUT, 1024: clkSys cycles allowed in each wait state before the access is aborted.
- TO_W, 11: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clkSys  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- p0_req  in  1  port-0 request; held with its qualifiers until p0_ack.
- p0_we  in  1  1=write, 0=read.
- p0_addr  in  24  byte address.
- p0_wdata  in  8  write data.
- p0_bank  in  1  PSRAM bank select.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  8  read data; valid with p0_ack, held until the next port-0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_bank, p1_ack, p1_rdata: same directions, widths and meanings as port 0, for port 1.
- o_cs  out  1  memCtrl i_cs, active-low start strobe.
- o_write  out  1  memCtrl i_write.
- o_address  out  24  memCtrl i_address.
- o_bank  out  1  memCtrl i_bank.
- o_dataToWrite  out  8  memCtrl i_dataToWrite.
- i_busy  in  1  memCtrl o_busy.
- i_dataReady  in  1  memCtrl o_dataReady.
- i_dataRead  in  8  memCtrl o_dataRead.
- o_grant  out  2  one-hot owner of the current access; 00 when idle (debug/VIC colour).
- o_timeout  out  1  sticky abort flag.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately, including mid-access):
  - o_cs=1, o_write=0, o_address=0, o_dataToWrite=0, o_bank=1.
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, o_grant=00, o_timeout=0.
  - Burst counter=0, timeout counter=0, state=IDLE.
- State machine, all outputs registered on posedge clkSys:
  - IDLE: if i_busy=0 and any req is high, select the winner and latch its we/addr/wdata/bank onto o_write/o_address/o_dataToWrite/o_bank. Set o_cs<=0, set o_grant, go to ISSUE. Otherwise stay in IDLE. If i_busy=1, no grant is made.
  - ISSUE: o_cs<=1, so o_cs is low for exactly one cycle. Clear the timeout counter and go to WAIT_START.
  - WAIT_START: if i_busy=1, clear the counter and go to WAIT_DONE. Otherwise increment the counter.
  - WAIT_DONE, write access: complete when i_busy=0.
  - WAIT_DONE, read access: complete when i_dataReady=1 and i_busy=0; i_dataRead is captured into the granted port's rdata on that edge. Otherwise increment the counter.
  - Completion: set the granted port's ack<=1 and go to DONE.
  - Timeout: if the counter reaches TIMEOUT-1 in WAIT_START or WAIT_DONE, abort the access. Set o_timeout<=1 (cleared only by reset), set ack<=1 for the granted port, and go to DONE. An aborted read loads rdata=8'hFF.
  - DONE: ack<=0, o_grant<=00, go to IDLE. All req inputs are ignored in DONE. The requester must drop req on the edge where it samples ack high.
- Arbitration in IDLE:
  - Only p0_req: grant port 0.
  - Only p1_req: grant port 1.
  - Both requesting: grant port 1 if burst counter == MAX_P0_BURST, otherwise grant port 0.
  - Burst counter: +1 on a port-0 grant made while p1_req=1; cleared on a port-0 grant made while p1_req=0; cleared on every port-1 grant; saturates at MAX_P0_BURST.
- Timing:
  - o_cs falls one clkSys edge after req is first sampled in IDLE.
  - Minimum occupancy is IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE (5 cycles) plus memCtrl busy time.
  - Back-to-back grants are separated by at least one IDLE cycle.
- The latched o_address/o_write/o_dataToWrite/o_bank hold their values until the next grant. Requester input changes after the grant have no effect.
- Only one access is outstanding at a time; there is no queueing.

Test Plan:
- Port-1 write: p1 req with we=1, addr=24'h000123, wdata=8'h5A; memCtrl model holds busy for 10 cycles -> o_cs low exactly 1 cycle with o_address=24'h000123, o_write=1, o_dataToWrite=8'h5A; p1_ack pulses once after busy falls; o_timeout stays 0.
- Port-0 read: model returns 8'hAA with dataReady -> p0_rdata=8'hAA while p0_ack=1, still 8'hAA afterwards; p1_rdata unchanged at 0.
- Simultaneous p0_req and p1_req in the same cycle -> o_grant=01 first, then 10; each ack pulses exactly once; no second o_cs strobe while the DONE state is active.
- Fairness with MAX_P0_BURST=2, p0_req held continuously, p1_req pending -> grant order 0,0,1,0,0,1.
- Timeout with TIMEOUT=16, model never raises busy, read request -> ack 16 cycles after entering WAIT_START; rdata=8'hFF; o_timeout=1 and sticky; a following normal access still completes.
- Reset asserted in WAIT_DONE -> o_cs=1, acks=0, o_grant=00, o_timeout=0 immediately without waiting for a clock edge; after release, the first request is granted normally.
